dataflow_start_sync_ctrl: RTL
=============================

// Module: dataflow_start_sync_ctrl
// PURPOSE
//  Top-level dataflow sequencer for myproject (Block_proc -> zeropad2d -> conv_2d chain).
//  Fans top ap_start out to N_IN input processes and merges their ap_ready through per-process ready-count flags.
//  Bounds in-flight iterations, produces top ap_done/ap_idle/ap_ready, and drives per-process stall flags for cosim deadlock reporting.
// PARAMETERS
//  N_IN       2    number of input processes sharing top ap_start
//  N_PROC     3    total dataflow processes (idle/stall monitoring)
//  MAX_INFL   2    max iterations in flight; 1..(2**CNT_W-1)
//  CNT_W      2    in-flight counter width
//  WD_LIMIT   1024 stall cycles before a process is flagged (watchdog only)
// PORTS
//  clock         in   1       clock, rising edge
//  reset         in   1       asynchronous, active-high reset
//  ap_start      in   1       top-level start
//  ap_ready      out  1       top-level ready; all input processes accepted this iteration
//  ap_done       out  1       top-level done; held until ap_continue
//  ap_continue   in   1       top-level continue
//  ap_idle       out  1       all processes idle and nothing in flight
//  proc_start    out  N_IN    ap_start to each input process
//  proc_ready    in   N_IN    ap_ready from each input process
//  proc_idle     in   N_PROC  ap_idle from every process
//  proc_blk      in   N_PROC  1 = process blocked on a FIFO (inverted *_blk_n)
//  last_done     in   1       ap_done of final process (conv_2d)
//  last_continue out  1       ap_continue to final process
//  dl_vec        out  N_PROC  sticky stall flags (watchdog); 0 when disabled
// BEHAVIOUR
//  Reset: state=IDLE, rdy_cnt=0, infl=0, done_reg=0; ap_ready=0, ap_done=0, ap_idle=1, proc_start=0, dl_vec=0, last_continue=0.
//  Reset mid-iteration abandons it; counts cleared, no ap_done produced.
//  rdy_cnt[i]: set when proc_ready[i] & ~ap_ready; cleared when ap_ready=1.
//  proc_start[i] = ap_start & ~rdy_cnt[i] & (state!=FULL)  (combinational).
//  ap_ready = (state!=FULL) & &(proc_ready | rdy_cnt)  (combinational; same cycle as last ready).
//  accept = ap_start & ap_ready; retire = ap_done & ap_continue.
//  infl: +1 on accept, -1 on retire, unchanged on both same cycle; never wraps.
//  done_reg: set on last_done & ~ap_continue; cleared on ap_continue. ap_done = last_done | done_reg.
//  last_continue = ap_continue (pass-through, 0-cycle).
//  ap_idle = &proc_idle & (infl==0) & ~done_reg.
//  FSM (registered): IDLE -accept-> RUN; RUN -infl_next==MAX_INFL-> FULL; RUN -infl_next==0-> IDLE;
//   FULL -retire-> RUN (or IDLE if MAX_INFL==1). FULL masks proc_start and ap_ready.
//  retire with infl==0 (spurious last_done) is ignored: infl held at 0, error flag asserts under sim.
// CONFIGURATION
//  STALL_WATCHDOG_EN defined: per-process counter increments while proc_blk[p] & ~proc_idle[p],
//   clears otherwise, saturates; reaching WD_LIMIT sets dl_vec[p], sticky until reset.
//  STALL_WATCHDOG_EN undefined: no counters; dl_vec tied to 0; port list unchanged.
// STRUCTURE
//  Package dataflow_ctrl_pkg: state enum {ST_IDLE, ST_RUN, ST_FULL} (2-bit), default widths/WD_LIMIT.
//  Sub-module dataflow_ready_sync: one instance per input process (rdy_cnt flag + proc_start gating).
//  Watchdog counters inline under the macro; FSM and in-flight counter in top.
// TESTING
//  1. ap_start=1; proc_ready[0] at cycle 3, proc_ready[1] at cycle 5 -> proc_start[0] drops at cycle 4,
//     ap_ready=1 only at cycle 5, rdy_cnt cleared at cycle 6.
//  2. MAX_INFL=2, ap_continue=0, two accepts -> state FULL, proc_start=0, ap_ready=0 until retire.
//  3. last_done 1 cycle with ap_continue=0 -> ap_done held high; ap_continue at +4 -> ap_done low next cycle, infl-1.
//  4. accept and retire same cycle with infl=1 -> infl stays 1, state RUN.
//  5. reset asserted mid-RUN with rdy_cnt=01 -> all outputs at reset values immediately; ap_idle=1 once proc_idle all 1.
//  6. STALL_WATCHDOG_EN, WD_LIMIT=16: proc_blk[1]=1, proc_idle[1]=0 for 16 cycles -> dl_vec=3'b010 sticky;
//     undefined -> dl_vec stays 0.

Source files
------------

// File: rtl/dataflow_ctrl_pkg.sv
// Shared types and defaults for the dataflow start/sync controller.
//  state_t      : controller state (idle / iterations running / in-flight limit reached)
//  *_DEF        : default parameter values used by the top level
//  wd_width()   : counter width able to hold a watchdog limit
package dataflow_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  localparam int N_IN_DEF     = 2;
  localparam int N_PROC_DEF   = 3;
  localparam int MAX_INFL_DEF = 2;
  localparam int CNT_W_DEF    = 2;
  localparam int WD_LIMIT_DEF = 1024;

  function automatic int wd_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dataflow_ready_sync.sv
// Per-input-process start/ready synchronizer.
//  clock, reset : clock and async active-high reset
//  ap_start     : top-level start
//  start_en     : controller allows starts (not at in-flight limit, not in reset)
//  proc_ready   : ap_ready of this input process
//  ap_ready     : merged top-level ready (closes the iteration for all processes)
//  proc_start   : ap_start to this process
//  rdy_cnt      : this process already accepted the current iteration
module dataflow_ready_sync (
  input  logic clock,
  input  logic reset,
  input  logic ap_start,
  input  logic start_en,
  input  logic proc_ready,
  input  logic ap_ready,
  output logic proc_start,
  output logic rdy_cnt
);

  // Remember an early ready so this process is not restarted while its
  // siblings are still catching up on the same iteration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           rdy_cnt <= 1'b0;
    else if (ap_ready)   rdy_cnt <= 1'b0;
    else if (proc_ready) rdy_cnt <= 1'b1;
  end

  assign proc_start = ap_start & ~rdy_cnt & start_en;

endmodule

// File: rtl/dataflow_start_sync_ctrl.sv
// Top-level dataflow sequencer: fans ap_start out to the input processes,
// merges their readies, bounds iterations in flight and produces the
// top-level ap_ready/ap_done/ap_idle handshake.
//  clock, reset   : clock, async active-high reset
//  ap_start/ap_ready/ap_done/ap_continue/ap_idle : top-level handshake
//  proc_start/proc_ready : per input process start/ready
//  proc_idle/proc_blk    : per process idle and FIFO-blocked status
//  last_done/last_continue : handshake with the final process
//  dl_vec         : sticky per-process stall flags
// Optional feature: define STALL_WATCHDOG_EN to build the stall watchdog;
// otherwise dl_vec is tied to zero.
module dataflow_start_sync_ctrl
  import dataflow_ctrl_pkg::*;
#(
  parameter int N_IN     = N_IN_DEF,
  parameter int N_PROC   = N_PROC_DEF,
  parameter int MAX_INFL = MAX_INFL_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int WD_LIMIT = WD_LIMIT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ap_start,
  output logic              ap_ready,
  output logic              ap_done,
  input  logic              ap_continue,
  output logic              ap_idle,
  output logic [N_IN-1:0]   proc_start,
  input  logic [N_IN-1:0]   proc_ready,
  input  logic [N_PROC-1:0] proc_idle,
  input  logic [N_PROC-1:0] proc_blk,
  input  logic              last_done,
  output logic              last_continue,
  output logic [N_PROC-1:0] dl_vec
);

  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_INFL);

  state_t           state, state_next;
  logic [CNT_W-1:0] infl, infl_next;
  logic             done_reg;
  logic [N_IN-1:0]  rdy_cnt;
  logic             start_en, accept, retire, retire_eff;

  // Handshake outputs are forced low while reset is held so nothing leaks
  // out of an abandoned iteration.
  assign start_en = (state != ST_FULL) & ~reset;

  for (genvar i = 0; i < N_IN; i++) begin : g_sync
    dataflow_ready_sync u_sync (
      .clock      (clock),
      .reset      (reset),
      .ap_start   (ap_start),
      .start_en   (start_en),
      .proc_ready (proc_ready[i]),
      .ap_ready   (ap_ready),
      .proc_start (proc_start[i]),
      .rdy_cnt    (rdy_cnt[i])
    );
  end

  assign ap_ready      = start_en & (&(proc_ready | rdy_cnt));
  assign ap_done       = ~reset & (last_done | done_reg);
  assign last_continue = ~reset & ap_continue;
  assign ap_idle       = (&proc_idle) & (infl == '0) & ~done_reg;

  assign accept     = ap_start & ap_ready;
  assign retire     = ap_done & ap_continue;
  // A done with nothing in flight is spurious and must not underflow.
  assign retire_eff = retire & (infl != '0);

  always_comb begin
    infl_next = infl;
    if (accept && !retire_eff && infl != '1) infl_next = infl + 1'b1;
    else if (retire_eff && !accept)          infl_next = infl - 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = (infl_next == MAX_W) ? ST_FULL : ST_RUN;
      ST_RUN: begin
        if (infl_next == MAX_W)   state_next = ST_FULL;
        else if (infl_next == '0) state_next = ST_IDLE;
      end
      ST_FULL: if (retire_eff) state_next = (infl_next == '0) ? ST_IDLE : ST_RUN;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      infl     <= '0;
      done_reg <= 1'b0;
    end else begin
      state <= state_next;
      infl  <= infl_next;
      if (ap_continue)    done_reg <= 1'b0;
      else if (last_done) done_reg <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset) assert (!(retire && infl == '0)) else $error("spurious done with nothing in flight");
  end
`endif

`ifdef STALL_WATCHDOG_EN
  localparam int WD_W = wd_width(WD_LIMIT);

  logic [N_PROC-1:0][WD_W-1:0] wd_cnt;
  logic [N_PROC-1:0]           dl_reg;

  // Count consecutive blocked, non-idle cycles; the flag latches on the
  // cycle the count reaches the limit and stays until reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      dl_reg <= '0;
    end else begin
      for (int p = 0; p < N_PROC; p++) begin
        if (proc_blk[p] & ~proc_idle[p]) begin
          if (wd_cnt[p] != WD_W'(WD_LIMIT)) wd_cnt[p] <= wd_cnt[p] + 1'b1;
          if (wd_cnt[p] == WD_W'(WD_LIMIT - 1)) dl_reg[p] <= 1'b1;
        end else begin
          wd_cnt[p] <= '0;
        end
      end
    end
  end

  assign dl_vec = dl_reg;
`else
  logic unused_wd;
  assign unused_wd = ^{proc_blk, WD_LIMIT[0]};
  assign dl_vec    = '0;
`endif

endmodule
